// File: rtl/puter_pkg.sv
// Shared encodings for the data bus arbiter: FSM states and the owner code
// presented to the rest of the system.
package puter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_M0   = 2'b01;
    localparam logic [1:0] OWNER_M1   = 2'b10;

endpackage

// File: rtl/data_bus_arbiter.sv
// Two-master data bus arbiter: round-robin on ties, burst-limited ownership
// when contested, combinational bus mux from the granted master.
module data_bus_arbiter
    import puter_pkg::*;
#(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m0_wenable,
    input  logic [3:0]  m1_wenable,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wenable,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  owner
);

    localparam logic [7:0] BURST_MAX   = 8'(MAX_BURST);
    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] burst_cnt;
    logic [7:0] burst_next;
    logic       last_owner;
    logic       last_owner_next;
    logic       transfer;

    // last_owner: 0 = m0, 1 = m1. Reset value m1 lets m0 win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            burst_cnt  <= 8'd0;
            last_owner <= 1'b1;
        end else begin
            state      <= state_next;
            burst_cnt  <= burst_next;
            last_owner <= last_owner_next;
        end
    end

    always_comb begin
        state_next      = state;
        burst_next      = burst_cnt;
        last_owner_next = last_owner;
        transfer        = (state == OWN0 && m0_req) || (state == OWN1 && m1_req);

        case (state)
            IDLE: begin
                if (m0_req && m1_req)
                    state_next = last_owner ? OWN0 : OWN1;
                else if (m0_req)
                    state_next = OWN0;
                else if (m1_req)
                    state_next = OWN1;
            end
            OWN0: begin
                if (!m0_req)
                    state_next = m1_req ? OWN1 : IDLE;
                else if (m1_req && burst_cnt >= BURST_LIMIT)
                    state_next = OWN1;
            end
            OWN1: begin
                if (!m1_req)
                    state_next = m0_req ? OWN0 : IDLE;
                else if (m0_req && burst_cnt >= BURST_LIMIT)
                    state_next = OWN0;
            end
            default: state_next = IDLE;
        endcase

        // Count restarts on every handover and saturates once the limit is reached.
        if (state_next != state)
            burst_next = 8'd0;
        else if (transfer && burst_cnt < BURST_MAX)
            burst_next = burst_cnt + 8'd1;

        if (state_next == OWN0)
            last_owner_next = 1'b0;
        else if (state_next == OWN1)
            last_owner_next = 1'b1;
    end

    always_comb begin
        bus_addr    = 32'd0;
        bus_wdata   = 32'd0;
        bus_wenable = 4'b0000;
        owner       = OWNER_NONE;
        case (state)
            OWN0: begin
                bus_addr    = m0_addr;
                bus_wdata   = m0_wdata;
                bus_wenable = m0_req ? m0_wenable : 4'b0000;
                owner       = OWNER_M0;
            end
            OWN1: begin
                bus_addr    = m1_addr;
                bus_wdata   = m1_wdata;
                bus_wenable = m1_req ? m1_wenable : 4'b0000;
                owner       = OWNER_M1;
            end
            default: ;
        endcase
    end

    assign m0_gnt   = (state == OWN0);
    assign m1_gnt   = (state == OWN1);
    assign m0_rdata = bus_rdata;
    assign m1_rdata = bus_rdata;

endmodule

// File: doc/data_bus_arbiter.md
DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 8, giving the maximum consecutive granted cycles before a forced handover when the other master waits (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports m0_req and m1_req, input, 1 each, asserted while the master wants the bus.
REQ-005 The block SHALL have ports m0_addr and m1_addr, input, 32 each, the byte address per master.
REQ-006 The block SHALL have ports m0_wdata and m1_wdata, input, 32 each, the write data per master.
REQ-007 The block SHALL have ports m0_wenable and m1_wenable, input, 4 each, byte write strobes; all-zero means read.
REQ-008 The block SHALL have ports m0_gnt and m1_gnt, output, 1 each, registered, never both high.
REQ-009 The block SHALL have ports m0_rdata and m1_rdata, output, 32 each, driven by bus_rdata.
REQ-010 The block SHALL have ports bus_addr (32), bus_wdata (32) and bus_wenable (4), all outputs, driving the shared data bus.
REQ-011 The block SHALL have port bus_rdata, input, 32, combinational read data from the decoded bus.
REQ-012 The block SHALL have port owner, output, 2, encoding 00 = none, 01 = m0, 10 = m1.

Function
REQ-013 The arbiter SHALL be a state machine with states IDLE, OWN0 and OWN1; mN_gnt SHALL equal (state == OWNN).
REQ-014 From IDLE, when exactly one request is high, the arbiter SHALL enter that master's OWN state at the next edge; the grant latency SHALL be one cycle.
REQ-015 From IDLE, when both requests are high, the arbiter SHALL grant the master that is not last_owner.
REQ-016 A transfer SHALL occur in each cycle where mN_gnt and mN_req are both high; one cycle per transfer, no wait states.
REQ-017 In OWNn, bus_addr, bus_wdata and bus_wenable SHALL be combinationally muxed from master n.
REQ-018 In IDLE, the bus outputs SHALL be zero.
REQ-019 In OWNn with mN_req low, bus_wenable SHALL be forced to 0000.
REQ-020 When the owner drops req, the arbiter SHALL go to the other OWN state at the next edge if the other master is requesting (no idle bubble), else to IDLE.
REQ-021 burst_cnt (8 bits) SHALL be cleared on every grant change.
REQ-022 burst_cnt SHALL increment each cycle the owner holds the bus with req high.
REQ-023 burst_cnt SHALL saturate at MAX_BURST.
REQ-024 When burst_cnt reaches MAX_BURST-1 during a transfer and the other master requests, the arbiter SHALL switch owner at that edge, so the owner gets exactly MAX_BURST transfers.
REQ-025 If the other master is not requesting, the owner SHALL keep the bus beyond MAX_BURST indefinitely.
REQ-026 If the owner drops req in the same cycle its burst limit is hit, REQ-020 SHALL apply; the outcome is the same.
REQ-027 last_owner SHALL update to n on entry to OWNn.
REQ-028 m0_rdata and m1_rdata SHALL both equal bus_rdata; the value is meaningful only to the granted master in a transfer cycle.
REQ-029 Writes issued by a non-granted master SHALL never reach bus_wenable.

Reset
REQ-030 While rst_n is low, the arbiter SHALL hold state = IDLE, both gnt = 0, owner = 00, burst_cnt = 0, last_owner = m1 (so m0 wins the first tie), and all bus outputs = 0, asynchronously.
REQ-031 On a reset asserted mid-burst, gnt and bus_wenable SHALL drop in the same instant, with no partial write after assertion.
REQ-032 After rst_n rises, the first grant SHALL occur no earlier than the first rising edge sampling a request.

Structure
REQ-033 The owner encodings (OWNER_NONE/M0/M1) and the state encodings SHALL be localparams in the shared puter_pkg package.
REQ-034 The block SHALL be a single module with no sub-module; the round-robin pick is two gates and SHALL not be split out.
REQ-035 The bus output mux SHALL be combinational, and the state, burst_cnt and last_owner SHALL be the only registers.

Verification
REQ-036 After reset, m0_req = 1 at edge 0 -> m0_gnt = 1 from edge 1, owner = 01; m0 write 0x8000_0010 / 0xDEAD_BEEF / 1111 appears on the bus that cycle.
REQ-037 From reset, both req high -> m0 granted first; both held with MAX_BURST = 8 -> exactly 8 m0 transfers, then m1_gnt with no idle cycle, then 8 m1 transfers, then m0.
REQ-038 m1 alone, req held for 20 cycles -> 20 consecutive transfers with m1_gnt continuously high and no forced handover.
REQ-039 m0 owns, m0 drops req while m1_req = 1 -> m1_gnt at the next edge; bus_wenable = 0000 in the gap cycle even though m0_wenable = 1111.
REQ-040 m1 writing 1111 at burst count 3, rst_n pulled low between edges -> m1_gnt and bus_wenable go to 0 immediately; after release, tie goes to m0.
REQ-041 Non-owner m1 drives wenable = 1111 throughout an m0 read burst -> bus_wenable stays 0000, and m0_rdata tracks bus_rdata.
